// File: rtl/fpu_ss_in_buf.sv
// Instruction input buffer for the FPU subsystem. It holds offloaded instructions with their ID.
// Entries killed through the commit interface are dropped at the head and never presented downstream.
module fpu_ss_in_buf #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned ID_WIDTH     = 4,
  parameter bit          FALL_THROUGH = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_valid_i,
  output logic                       push_ready_o,
  input  logic [DATA_WIDTH-1:0]      push_data_i,
  input  logic [ID_WIDTH-1:0]        push_id_i,
  output logic                       pop_valid_o,
  input  logic                       pop_ready_i,
  output logic [DATA_WIDTH-1:0]      pop_data_o,
  output logic [ID_WIDTH-1:0]        pop_id_o,
  input  logic                       x_commit_valid_i,
  input  logic [ID_WIDTH-1:0]        x_commit_id_i,
  input  logic                       x_commit_kill_i,
  output logic [$clog2(DEPTH+1)-1:0] usage_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  if (DEPTH < 2 || DEPTH > 16) begin : g_depth_check
    $error("fpu_ss_in_buf: DEPTH must be within 2..16");
  end

  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [ID_WIDTH-1:0]   id_q   [DEPTH];
  logic [DEPTH-1:0]      killed_q;
  logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;

  logic kill_valid, push_kill, empty, head_killed, head_live;
  logic ft_hit, bypass, write_en, pop_fire, drop, rd_adv;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign kill_valid  = x_commit_valid_i & x_commit_kill_i;
  assign push_kill   = kill_valid && (push_id_i == x_commit_id_i);
  assign empty       = (count_q == '0);
  assign head_killed = !empty && killed_q[rd_ptr_q];
  assign head_live   = !empty && !killed_q[rd_ptr_q];

  // Fall-through only when empty and the incoming ID is not being killed this cycle
  assign ft_hit       = FALL_THROUGH && empty && push_valid_i && !push_kill;
  assign push_ready_o = (count_q < CNT_W'(DEPTH));
  assign pop_valid_o  = !flush_i && (ft_hit || head_live);
  assign pop_data_o   = ft_hit ? push_data_i : data_q[rd_ptr_q];
  assign pop_id_o     = ft_hit ? push_id_i   : id_q[rd_ptr_q];
  assign usage_o      = count_q;

  assign bypass   = ft_hit && pop_ready_i;
  assign write_en = push_valid_i && push_ready_o && !flush_i && !bypass;
  assign pop_fire = head_live && pop_ready_i;
  assign drop     = head_killed;
  assign rd_adv   = pop_fire || drop;

  always_comb begin
    count_d = count_q;
    if (write_en && !rd_adv) begin
      count_d = count_q + 1'b1;
    end else if (!write_en && rd_adv) begin
      count_d = count_q - 1'b1;
    end
  end

  // A fresh write overrides any stale kill match on the slot being written
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      killed_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= '0;
        id_q[i]   <= '0;
      end
    end else if (flush_i) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      killed_q <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (kill_valid && (id_q[i] == x_commit_id_i)) begin
          killed_q[i] <= 1'b1;
        end
      end
      if (write_en) begin
        data_q[wr_ptr_q]   <= push_data_i;
        id_q[wr_ptr_q]     <= push_id_i;
        killed_q[wr_ptr_q] <= push_kill;
        wr_ptr_q           <= ptr_inc(wr_ptr_q);
      end
      if (rd_adv) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_d;
    end
  end

endmodule
